// File: rtl/key_note_select_pkg.sv
// Shared constants for the key-to-note front end: key count, note terminal-count table, FSM states.
// Terminal counts assume a 50 MHz clock; the downstream counter runs 0..period and wraps.
// Pure declarations; no storage, no flow control.
package key_note_pkg;

    localparam int NUM_KEYS = 8;

    localparam logic [15:0] NOTE_C6 = 16'd47777;
    localparam logic [15:0] NOTE_D6 = 16'd42565;
    localparam logic [15:0] NOTE_E6 = 16'd37921;
    localparam logic [15:0] NOTE_F6 = 16'd35793;
    localparam logic [15:0] NOTE_G6 = 16'd31887;
    localparam logic [15:0] NOTE_A6 = 16'd28408;
    localparam logic [15:0] NOTE_B6 = 16'd25309;
    localparam logic [15:0] NOTE_C7 = 16'd23888;

    typedef enum logic {
        IDLE,
        PLAYING
    } state_t;

    function automatic logic [15:0] note_period(input logic [2:0] idx);
        logic [15:0] tc;
        case (idx)
            3'd0:    tc = NOTE_C6;
            3'd1:    tc = NOTE_D6;
            3'd2:    tc = NOTE_E6;
            3'd3:    tc = NOTE_F6;
            3'd4:    tc = NOTE_G6;
            3'd5:    tc = NOTE_A6;
            3'd6:    tc = NOTE_B6;
            default: tc = NOTE_C7;
        endcase
        return tc;
    endfunction

endpackage

// File: rtl/key_note_select_if.sv
// Key inputs and note outputs between the key front end and its neighbours.
// Latency set by the slave; no handshake, outputs are plain registered levels/strobes.
// No backpressure: the downstream counter always accepts a new period.
interface key_note_select_if #(
    parameter int PERIOD_W = 16
);
    logic [7:0]          keys;
    logic [PERIOD_W-1:0] period;
    logic                note_on;
    logic [2:0]          note_idx;
    logic                period_load;

    modport master (
        output keys,
        input  period,
        input  note_on,
        input  note_idx,
        input  period_load
    );

    modport slave (
        input  keys,
        output period,
        output note_on,
        output note_idx,
        output period_load
    );
endinterface

// File: rtl/key_debouncer.sv
// One key: 2-flop synchroniser, mismatch run counter, debounced stable bit.
// stable flips DEBOUNCE_CYCLES+2 edges after a held change on key.
// No backpressure; pulses shorter than DEBOUNCE_CYCLES synced cycles are dropped.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic stable
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            // Any agreeing cycle restarts the run, so only an unbroken mismatch flips stable.
            if (sync2 != stable) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable <= ~stable;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/key_note_select.sv
// Debounces 8 piano keys and emits the highest held key's divider terminal count.
// Outputs follow a held key change by DEBOUNCE_CYCLES+3 edges, all registered.
// No backpressure; period_load pulses one cycle per new nonzero period.
module key_note_select
    import key_note_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PERIOD_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    key_note_select_if.slave  bus
);
    logic [NUM_KEYS-1:0] stable;
    logic                any_held;
    logic [2:0]          win_idx;
    state_t              state;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .key    (bus.keys[k]),
            .stable (stable[k])
        );
    end

    // Ascending scan so the highest set index is the last one written.
    always_comb begin
        any_held = |stable;
        win_idx  = 3'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (stable[i]) begin
                win_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.period      <= '0;
            bus.note_on     <= 1'b0;
            bus.note_idx    <= 3'd0;
            bus.period_load <= 1'b0;
        end else begin
            bus.period_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_held) begin
                        state           <= PLAYING;
                        bus.period      <= PERIOD_W'(note_period(win_idx));
                        bus.note_idx    <= win_idx;
                        bus.note_on     <= 1'b1;
                        bus.period_load <= 1'b1;
                    end
                end
                PLAYING: begin
                    if (!any_held) begin
                        state        <= IDLE;
                        bus.period   <= '0;
                        bus.note_idx <= 3'd0;
                        bus.note_on  <= 1'b0;
                    end else if (win_idx != bus.note_idx) begin
                        bus.period      <= PERIOD_W'(note_period(win_idx));
                        bus.note_idx    <= win_idx;
                        bus.period_load <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_note_select.sv
// Bench for key_note_select: directed scenarios plus random key traffic against a history-based model.
module tb_key_note_select;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    key_note_select_if #(.PERIOD_W(16)) bus ();

    key_note_select #(
        .DEBOUNCE_CYCLES(D),
        .PERIOD_W       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] note_tc [8] = '{16'd47777, 16'd42565, 16'd37921, 16'd35793,
                                 16'd31887, 16'd28408, 16'd25309, 16'd23888};

    // Reference: a key's debounced level changes once its last D synced samples all disagree with it.
    logic [7:0]  m_stab;
    logic [7:0]  samp [$];
    logic [7:0]  hist [$];
    logic [7:0]  m_synced;
    logic        m_diff;
    int          m_top;
    logic [15:0] e_period;
    logic        e_on;
    logic [2:0]  e_idx;
    logic        e_load;

    function automatic int top_key(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stab = 8'h00;
            samp   = {8'h00, 8'h00};
            hist   = {};
            {e_period, e_on, e_idx, e_load} = '0;
        end else begin
            m_top = top_key(m_stab);
            if (m_top < 0) begin
                {e_period, e_on, e_idx, e_load} = '0;
            end else begin
                e_load   = !e_on || (e_idx != 3'(m_top));
                e_on     = 1'b1;
                e_idx    = 3'(m_top);
                e_period = note_tc[m_top];
            end
            m_synced = samp.pop_front();
            samp.push_back(bus.keys);
            hist.push_back(m_synced);
            if (hist.size() > D) void'(hist.pop_front());
            if (hist.size() == D) begin
                for (int k = 0; k < 8; k++) begin
                    m_diff = 1'b1;
                    foreach (hist[j]) if (hist[j][k] == m_stab[k]) m_diff = 1'b0;
                    if (m_diff) m_stab[k] = ~m_stab[k];
                end
            end
        end
    end

    task automatic test_reset;
        bus.keys = 8'hFF;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.period, bus.note_on, bus.note_idx, bus.period_load} !== 21'd0) begin
            errors++;
            $display("FAIL reset_hold: got period=%0d on=%b idx=%0d load=%b, want all 0",
                     bus.period, bus.note_on, bus.note_idx, bus.period_load);
        end
        bus.keys = 8'h00;
        rst_n    = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.period, bus.note_on, bus.note_idx, bus.period_load} !== 21'd0) begin
                errors++;
                $display("FAIL reset_idle c=%0d: got period=%0d on=%b idx=%0d load=%b, want all 0",
                         c, bus.period, bus.note_on, bus.note_idx, bus.period_load);
            end
        end
    endtask

    task automatic test_single_press;
        bus.keys = 8'h20;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            checks++;
            if ({bus.period, bus.note_on, bus.note_idx, bus.period_load} !== {e_period, e_on, e_idx, e_load}) begin
                errors++;
                $display("FAIL press_model e=%0d: got %0d/%b/%0d/%b want %0d/%b/%0d/%b", e,
                         bus.period, bus.note_on, bus.note_idx, bus.period_load, e_period, e_on, e_idx, e_load);
            end
            if (e == 6) begin
                checks++;
                if (bus.note_on !== 1'b0) begin
                    errors++;
                    $display("FAIL press_early: note_on=%b at edge 6, want 0", bus.note_on);
                end
            end
            if (e == 7) begin
                checks++;
                if ({bus.period, bus.note_on, bus.note_idx, bus.period_load} !== {16'd28408, 1'b1, 3'd5, 1'b1}) begin
                    errors++;
                    $display("FAIL press_edge7: got %0d/%b/%0d/%b want 28408/1/5/1",
                             bus.period, bus.note_on, bus.note_idx, bus.period_load);
                end
            end
            if (e == 8) begin
                checks++;
                if ({bus.period, bus.period_load} !== {16'd28408, 1'b0}) begin
                    errors++;
                    $display("FAIL press_edge8: got period=%0d load=%b want 28408/0", bus.period, bus.period_load);
                end
            end
        end
    endtask

    task automatic test_short_pulse;
        bus.keys = 8'h24;
        repeat (3) @(negedge clk);
        bus.keys = 8'h20;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.period, bus.note_on, bus.note_idx, bus.period_load} !== {16'd28408, 1'b1, 3'd5, 1'b0}) begin
                errors++;
                $display("FAIL short_pulse c=%0d: got %0d/%b/%0d/%b want 28408/1/5/0", c,
                         bus.period, bus.note_on, bus.note_idx, bus.period_load);
            end
        end
    endtask

    task automatic test_switch;
        logic [7:0]  pat [3] = '{8'h02, 8'h42, 8'h02};
        logic [15:0] tgt [3] = '{16'd42565, 16'd25309, 16'd42565};
        int loads;
        bit hit;
        for (int s = 0; s < 3; s++) begin
            bus.keys = pat[s];
            loads    = 0;
            hit      = 1'b0;
            for (int c = 0; c < 20 && !hit; c++) begin
                @(negedge clk);
                if (bus.period_load === 1'b1) loads++;
                if (bus.period === tgt[s]) hit = 1'b1;
                checks++;
                if ({bus.period, bus.note_on, bus.note_idx, bus.period_load} !== {e_period, e_on, e_idx, e_load}) begin
                    errors++;
                    $display("FAIL switch_model s=%0d c=%0d: got %0d/%b/%0d/%b want %0d/%b/%0d/%b", s, c,
                             bus.period, bus.note_on, bus.note_idx, bus.period_load, e_period, e_on, e_idx, e_load);
                end
            end
            repeat (3) begin
                @(negedge clk);
                if (bus.period_load === 1'b1) loads++;
            end
            checks++;
            if (!hit || loads != 1) begin
                errors++;
                $display("FAIL switch s=%0d: reached=%0b loads=%0d period=%0d, want period %0d with 1 load",
                         s, hit, loads, bus.period, tgt[s]);
            end
        end
    endtask

    task automatic test_release_all;
        int loads = 0;
        bus.keys = 8'h00;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            if (bus.period_load === 1'b1) loads++;
            if (e == 6) begin
                checks++;
                if (bus.period !== 16'd42565) begin
                    errors++;
                    $display("FAIL release_early: period=%0d at edge 6, want 42565", bus.period);
                end
            end
        end
        checks++;
        if ({bus.period, bus.note_on, bus.note_idx, bus.period_load} !== 21'd0 || loads != 0) begin
            errors++;
            $display("FAIL release_all: got %0d/%b/%0d/%b loads=%0d want 0/0/0/0 loads=0",
                     bus.period, bus.note_on, bus.note_idx, bus.period_load, loads);
        end
    endtask

    task automatic test_async_reset;
        bit hit = 1'b0;
        int first = 0;
        bus.keys = 8'h80;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (bus.period === 16'd23888) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL arst_setup: period=%0d, want 23888", bus.period);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.period, bus.note_on, bus.note_idx, bus.period_load} !== 21'd0) begin
            errors++;
            $display("FAIL arst_immediate: got %0d/%b/%0d/%b want all 0",
                     bus.period, bus.note_on, bus.note_idx, bus.period_load);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            if (first == 0 && bus.period === 16'd23888) first = e;
            checks++;
            if ({bus.period, bus.note_on, bus.note_idx, bus.period_load} !== {e_period, e_on, e_idx, e_load}) begin
                errors++;
                $display("FAIL arst_model e=%0d: got %0d/%b/%0d/%b want %0d/%b/%0d/%b", e,
                         bus.period, bus.note_on, bus.note_idx, bus.period_load, e_period, e_on, e_idx, e_load);
            end
        end
        checks++;
        if (first != D + 3) begin
            errors++;
            $display("FAIL arst_relatch: period reached 23888 at edge %0d, want %0d", first, D + 3);
        end
    endtask

    task automatic test_random;
        int hold;
        for (int n = 0; n < 300; n++) begin
            bus.keys = 8'($urandom);
            if ($urandom_range(0, 3) == 0) bus.keys = 8'h00;
            hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(D, 12)) : int'($urandom_range(1, D));
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                checks++;
                if ({bus.period, bus.note_on, bus.note_idx, bus.period_load} !== {e_period, e_on, e_idx, e_load}) begin
                    errors++;
                    $display("FAIL random n=%0d keys=%h: got %0d/%b/%0d/%b want %0d/%b/%0d/%b", n, bus.keys,
                             bus.period, bus.note_on, bus.note_idx, bus.period_load, e_period, e_on, e_idx, e_load);
                end
            end
        end
    endtask

    initial begin
        bus.keys = 8'h00;
        #1;
        test_reset();
        test_single_press();
        test_short_pulse();
        test_switch();
        test_release_all();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_note_select.md
Name: key_note_select

Overview:
- Upstream stage of the tone generator. Turns 8 raw piano-key switches into one divider terminal count for the downstream square-wave counter.
- Synchronises and debounces each key, then picks the highest-index pressed key.
- Outputs that key's terminal count (period) with a note_on flag and a load strobe.
- Downstream counter counts 0..period and wraps; period=0 parks it at 0 (silence).

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive cycles a synchronised key must differ from its stable state before the stable state flips (5 ms @ 50 MHz). Must be ≥1.
- PERIOD_W, 16, width of period output; all table values fit in 16 bits.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset
- keys  in  8  raw key switches, active-high, asynchronous to clk, bounce expected
- period  out  PERIOD_W  terminal count for downstream counter; 0 when silent
- note_on  out  1  high while any debounced key is held
- note_idx  out  3  index of selected key; 0 when silent
- period_load  out  1  one-cycle strobe, high in the cycle period takes a new nonzero value

Interface (already decided): one clock; reset is asynchronous and active-low. Ports are clk and rst_n.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - period=0, note_on=0, note_idx=0, period_load=0.
  - All synchronisers, debounce counters and stable states cleared to 0.
  - FSM goes to IDLE.
- Per key:
  - 2-flop synchroniser feeding a debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Each cycle the synced value differs from stable, the counter increments.
  - When the counter is at DEBOUNCE_CYCLES-1 and the mismatch persists, stable flips and the counter clears.
  - Any cycle with synced == stable clears the counter. A pulse shorter than DEBOUNCE_CYCLES synced cycles never changes stable.
- Selection: combinational priority over the 8 stable bits; highest set index wins.
- Note table, terminal counts for 50 MHz, fixed: idx0 C6=47777, idx1 D6=42565, idx2 E6=37921, idx3 F6=35793, idx4 G6=31887, idx5 A6=28408, idx6 B6=25309, idx7 C7=23888.
- FSM:
  - IDLE: outputs at reset values. Any stable bit set → PLAYING; registers period/note_idx for the winner, note_on=1, period_load=1.
  - PLAYING, same winner: hold outputs, period_load=0.
  - PLAYING, different winner (press of higher key, or release of current highest while a lower key is still held): update period/note_idx, period_load=1 for exactly one cycle.
  - PLAYING, no stable bits: → IDLE; period=0, note_idx=0, note_on=0, period_load=0.
- Latency:
  - Key rising at sampling edge 1 and held → stable flips at edge DEBOUNCE_CYCLES+2.
  - Outputs update at edge DEBOUNCE_CYCLES+3. Release is symmetric.
- Simultaneous stable flips on several keys in one cycle resolve in a single update (one period_load).
- All outputs are registered; no combinational path from keys.

Decomposition:
- Package key_note_pkg holds:
  - NUM_KEYS=8
  - the 8-entry note-table constants
  - FSM state typedef {IDLE, PLAYING}
- Sub-module key_debouncer (one key: synchroniser + counter + stable bit, parameter DEBOUNCE_CYCLES), instantiated 8 times.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
1. Hold rst_n low with keys=8'hFF → period=0, note_on=0, note_idx=0, period_load=0. Release rst_n, keys=0 for 20 cycles → outputs unchanged.
2. Raise keys[5] at edge 1 and hold → at edge 7: period=28408, note_idx=5, note_on=1, period_load=1. At edge 8: period_load=0.
3. Pulse keys[2] high for 3 cycles, then low → no output change for 20 cycles.
4. Hold keys[1] until period=42565, then add keys[6] → period=25309 with one period_load pulse. Release keys[6] → period=42565 with one period_load pulse.
5. Release all keys while PLAYING → 7 edges later: period=0, note_on=0, note_idx=0, no period_load pulse.
6. Assert rst_n mid-note with keys[7] held → outputs clear in the same cycle, without waiting for clk. Deassert rst_n with keys[7] still held → period=23888 only after a full DEBOUNCE_CYCLES+3 edges.
